pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Parametrised pipeline hazard controller, successor to the jump-only Ctrl of the in-order RV64 pipeline. It adds three things to branch redirect: per-stage stall and flush vectors, load-use interlock, and multi-cycle memory-wait stalling. A watchdog catches memory waits that never complete. Sits beside the pipeline registers (Pc, If2Id, Id2Ex, Ex2Mem, Mem2Wb) and replaces the single HoldFlag.

Parameters:
STAGES, 5, number of pipeline registers controlled; bit 0 = Pc, 1 = If2Id, 2 = Id2Ex, 3 = Ex2Mem, 4 = Mem2Wb; minimum 3.
ADDR_W, 64, jump address width.
REG_AW, 5, register file address width.
FLUSH_CYCLES, 1, cycles If2Id is flushed after a taken jump; minimum 1.
MAX_STALL, 255, memory-wait cycles before watchdog fires; minimum 1.

Ports:
Clk  in  1  clock
Rst  in  1  synchronous active-high reset
JumpFlagFromEx  in  1  taken jump/branch in Ex
JumpAddrFromEx  in  ADDR_W  jump target
ExIsLoad  in  1  instruction in Ex is a load
ExRdAddr  in  REG_AW  rd of instruction in Ex
IdRs1Addr  in  REG_AW  rs1 of instruction in Id
IdRs1ReadEnable  in  1  rs1 used
IdRs2Addr  in  REG_AW  rs2 of instruction in Id
IdRs2ReadEnable  in  1  rs2 used
MemReq  in  1  Mem stage has an access in flight
MemReady  in  1  access completes this cycle
JumpFlagToPc  out  1  redirect Pc
JumpAddrToPc  out  ADDR_W  redirect target
StallOut  out  STAGES  1 = hold register i
FlushOut  out  STAGES  1 = load bubble into register i
Timeout  out  1  sticky watchdog flag
PerfStallCnt  out  32  memory-wait stall cycles
PerfFlushCnt  out  32  accepted jumps
PerfLoadUseCnt  out  32  load-use bubbles

Behaviour:
- Reset (synchronous, Rst=1 at posedge):
  - state=RUN; flush counter, watchdog counter and saved state cleared.
  - Timeout=0; perf counters 0.
  - Combinational outputs are 0 while in RUN with no inputs active.
- States: RUN, MEM_WAIT, FLUSH. Every output is combinational from the current state and inputs; there is no added latency.
- Priority (highest first): memory wait, then jump, then load-use.
- Memory wait: MemReq=1 and MemReady=0 in RUN or FLUSH.
  - StallOut = all ones and FlushOut = 0 in the same cycle.
  - Next state MEM_WAIT; the prior state and the remaining flush count are saved.
- MEM_WAIT:
  - StallOut = all ones while MemReady=0; the watchdog counter increments each cycle.
  - The cycle MemReady=1: StallOut = 0 and the watchdog clears. Next state is the saved state (FLUSH if flush count is nonzero, else RUN).
  - Jump and load-use requests are ignored in MEM_WAIT; Ex is held, so they re-present after exit.
  - When the watchdog reaches MAX_STALL: Timeout sets (sticky until Rst), stalls release and the next state is RUN.
- Jump, accepted in RUN or FLUSH when no memory wait:
  - JumpFlagToPc=1 and JumpAddrToPc=JumpAddrFromEx in the same cycle.
  - FlushOut[1] and FlushOut[2] are set.
  - If FLUSH_CYCLES>1: load the counter with FLUSH_CYCLES-1 and go to FLUSH; otherwise stay in RUN.
  - JumpAddrToPc = 0 when JumpFlagToPc=0.
- FLUSH:
  - FlushOut[1]=1 each cycle and the counter decrements; RUN when it reaches 0.
  - A new jump reloads the counter.
- Load-use: in RUN, no jump, ExIsLoad=1, ExRdAddr!=0, and ExRdAddr matches an enabled Id rs.
  - StallOut[0]=StallOut[1]=1 and FlushOut[2]=1 for that cycle; state stays RUN.
- Jump in the same cycle as load-use: the jump wins and the load-use is dropped, because the Id instruction is flushed.
- Asserting Rst mid-MEM_WAIT or mid-FLUSH gives full reset on the next edge; pending redirects are lost.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: three 32-bit wrapping counters.
  - PerfStallCnt increments each MEM_WAIT stall cycle.
  - PerfFlushCnt increments per accepted jump.
  - PerfLoadUseCnt increments per load-use bubble.
  - All three are cleared by Rst.
- Undefined: the ports remain and are tied to 0; no counter flops are built.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN/MEM_WAIT/FLUSH);
  - stage index constants (STG_PC=0, STG_IF2ID=1, STG_ID2EX=2, STG_EX2MEM=3, STG_MEM2WB=4).
- One natural sub-module: pipe_ctrl_hazard, purely combinational load-use comparator producing one bit.

Test Plan:
- Rst held 2 cycles then released, no inputs → all outputs 0, state RUN.
- JumpFlagFromEx=1, JumpAddrFromEx=0x80000100, FLUSH_CYCLES=3 → same cycle: JumpFlagToPc=1, addr 0x80000100, FlushOut=5'b00110; next 2 cycles FlushOut=5'b00010; then 0.
- ExIsLoad=1, ExRdAddr=5, IdRs2Addr=5, IdRs2ReadEnable=1 → StallOut=5'b00011, FlushOut=5'b00100 for 1 cycle; repeat with ExRdAddr=0 → no stall.
- MemReq=1, MemReady=0 for 4 cycles then MemReady=1 → StallOut=5'b11111 for 4 cycles, 0 on the 5th; PerfStallCnt=4 with PIPE_CTRL_PERF_EN.
- MEM_WAIT with MemReady never asserted, MAX_STALL=8 → after 8 cycles Timeout=1 (stays 1), StallOut=0, state RUN; Rst clears Timeout.
- Jump and load-use in the same cycle → JumpFlagToPc=1, FlushOut=5'b00110, StallOut=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    localparam int STG_PC     = 0;
    localparam int STG_IF2ID  = 1;
    localparam int STG_ID2EX  = 2;
    localparam int STG_EX2MEM = 3;
    localparam int STG_MEM2WB = 4;

    // Width of a down/up counter that must hold values 0..n (at least 1 bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Load-use comparator: the load in Ex writes a register the Id instruction reads.
module pipe_ctrl_hazard #(
    parameter int REG_AW = 5
) (
    input  logic              i_ex_is_load,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic              i_rs1_en,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic              i_rs2_en,
    output logic              o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_rs1_en && (i_rs1 == i_ex_rd);
    assign w_rs2_hit  = i_rs2_en && (i_rs2 == i_ex_rd);
    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign o_load_use = i_ex_is_load && (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: jump redirect/flush, load-use interlock, memory-wait stall, watchdog.
// Performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES       = 5,
    parameter int ADDR_W       = 64,
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_STALL    = 255
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              JumpFlagFromEx,
    input  logic [ADDR_W-1:0] JumpAddrFromEx,
    input  logic              ExIsLoad,
    input  logic [REG_AW-1:0] ExRdAddr,
    input  logic [REG_AW-1:0] IdRs1Addr,
    input  logic              IdRs1ReadEnable,
    input  logic [REG_AW-1:0] IdRs2Addr,
    input  logic              IdRs2ReadEnable,
    input  logic              MemReq,
    input  logic              MemReady,
    output logic              JumpFlagToPc,
    output logic [ADDR_W-1:0] JumpAddrToPc,
    output logic [STAGES-1:0] StallOut,
    output logic [STAGES-1:0] FlushOut,
    output logic              Timeout,
    output logic [31:0]       PerfStallCnt,
    output logic [31:0]       PerfFlushCnt,
    output logic [31:0]       PerfLoadUseCnt
);

    localparam int FC_W = cnt_w(FLUSH_CYCLES);
    localparam int WD_W = cnt_w(MAX_STALL);

    state_e          r_state, w_next_state;
    state_e          r_saved_state, w_saved_state_nxt;
    logic [FC_W-1:0] r_flush_cnt, w_flush_cnt_nxt;
    logic [FC_W-1:0] r_saved_cnt, w_saved_cnt_nxt;
    logic [WD_W-1:0] r_wd_cnt, w_wd_cnt_nxt;
    logic            r_timeout;

    logic w_load_use;
    logic w_mem_stall;
    logic w_jump;
    logic w_flush_slot;
    logic w_lu_acc;
    logic w_wd_fire;

    pipe_ctrl_hazard #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .i_ex_is_load (ExIsLoad),
        .i_ex_rd      (ExRdAddr),
        .i_rs1        (IdRs1Addr),
        .i_rs1_en     (IdRs1ReadEnable),
        .i_rs2        (IdRs2Addr),
        .i_rs2_en     (IdRs2ReadEnable),
        .o_load_use   (w_load_use)
    );

    always_comb begin
        w_next_state      = r_state;
        w_saved_state_nxt = r_saved_state;
        w_flush_cnt_nxt   = r_flush_cnt;
        w_saved_cnt_nxt   = r_saved_cnt;
        w_wd_cnt_nxt      = r_wd_cnt;
        w_mem_stall       = 1'b0;
        w_jump            = 1'b0;
        w_flush_slot      = 1'b0;
        w_lu_acc          = 1'b0;
        w_wd_fire         = 1'b0;
        case (r_state)
            ST_MEM_WAIT: begin
                // Ex is frozen here, so any jump or load-use re-presents after exit.
                if (MemReady) begin
                    w_next_state    = r_saved_state;
                    w_flush_cnt_nxt = r_saved_cnt;
                    w_wd_cnt_nxt    = '0;
                end else if (r_wd_cnt >= WD_W'(MAX_STALL)) begin
                    w_wd_fire       = 1'b1;
                    w_next_state    = ST_RUN;
                    w_flush_cnt_nxt = '0;
                    w_wd_cnt_nxt    = '0;
                end else begin
                    w_mem_stall  = 1'b1;
                    w_wd_cnt_nxt = r_wd_cnt + WD_W'(1);
                end
            end
            default: begin
                if (MemReq && !MemReady) begin
                    // The entry cycle is the first stall cycle the watchdog counts.
                    w_mem_stall       = 1'b1;
                    w_next_state      = ST_MEM_WAIT;
                    w_saved_state_nxt = r_state;
                    w_saved_cnt_nxt   = r_flush_cnt;
                    w_wd_cnt_nxt      = WD_W'(1);
                end else if (JumpFlagFromEx) begin
                    w_jump = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
                        w_next_state    = ST_FLUSH;
                    end else begin
                        w_flush_cnt_nxt = '0;
                        w_next_state    = ST_RUN;
                    end
                end else if (r_state == ST_FLUSH) begin
                    w_flush_slot    = 1'b1;
                    w_flush_cnt_nxt = r_flush_cnt - FC_W'(1);
                    if (r_flush_cnt <= FC_W'(1))
                        w_next_state = ST_RUN;
                end else if (w_load_use) begin
                    w_lu_acc = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state       <= ST_RUN;
            r_saved_state <= ST_RUN;
            r_flush_cnt   <= '0;
            r_saved_cnt   <= '0;
            r_wd_cnt      <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_saved_state <= w_saved_state_nxt;
            r_flush_cnt   <= w_flush_cnt_nxt;
            r_saved_cnt   <= w_saved_cnt_nxt;
            r_wd_cnt      <= w_wd_cnt_nxt;
            r_timeout     <= r_timeout | w_wd_fire;
        end
    end

    always_comb begin
        StallOut = '0;
        FlushOut = '0;
        if (w_mem_stall)
            StallOut = '1;
        if (w_lu_acc) begin
            StallOut[STG_PC]    = 1'b1;
            StallOut[STG_IF2ID] = 1'b1;
            FlushOut[STG_ID2EX] = 1'b1;
        end
        if (w_jump) begin
            FlushOut[STG_IF2ID] = 1'b1;
            FlushOut[STG_ID2EX] = 1'b1;
        end
        if (w_flush_slot)
            FlushOut[STG_IF2ID] = 1'b1;
    end

    assign JumpFlagToPc = w_jump;
    assign JumpAddrToPc = w_jump ? JumpAddrFromEx : '0;
    assign Timeout      = r_timeout | w_wd_fire;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_lu;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_lu    <= '0;
        end else begin
            if (w_mem_stall) r_perf_stall <= r_perf_stall + 32'd1;
            if (w_jump)      r_perf_flush <= r_perf_flush + 32'd1;
            if (w_lu_acc)    r_perf_lu    <= r_perf_lu + 32'd1;
        end
    end

    assign PerfStallCnt   = r_perf_stall;
    assign PerfFlushCnt   = r_perf_flush;
    assign PerfLoadUseCnt = r_perf_lu;
`else
    assign PerfStallCnt   = '0;
    assign PerfFlushCnt   = '0;
    assign PerfLoadUseCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vectors, literal expectations, and a per-cycle reference model.
module tb_pipe_ctrl;

    localparam int FC = 3;
    localparam int MS = 8;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        JumpFlagFromEx = 1'b0;
    logic [63:0] JumpAddrFromEx = '0;
    logic        ExIsLoad = 1'b0;
    logic [4:0]  ExRdAddr = '0;
    logic [4:0]  IdRs1Addr = '0;
    logic        IdRs1ReadEnable = 1'b0;
    logic [4:0]  IdRs2Addr = '0;
    logic        IdRs2ReadEnable = 1'b0;
    logic        MemReq = 1'b0;
    logic        MemReady = 1'b0;
    logic        JumpFlagToPc;
    logic [63:0] JumpAddrToPc;
    logic [4:0]  StallOut;
    logic [4:0]  FlushOut;
    logic        Timeout;
    logic [31:0] PerfStallCnt;
    logic [31:0] PerfFlushCnt;
    logic [31:0] PerfLoadUseCnt;

    int n_pass = 0;
    int n_total = 0;

    pipe_ctrl #(
        .STAGES(5), .ADDR_W(64), .REG_AW(5), .FLUSH_CYCLES(FC), .MAX_STALL(MS)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .JumpFlagFromEx(JumpFlagFromEx), .JumpAddrFromEx(JumpAddrFromEx),
        .ExIsLoad(ExIsLoad), .ExRdAddr(ExRdAddr),
        .IdRs1Addr(IdRs1Addr), .IdRs1ReadEnable(IdRs1ReadEnable),
        .IdRs2Addr(IdRs2Addr), .IdRs2ReadEnable(IdRs2ReadEnable),
        .MemReq(MemReq), .MemReady(MemReady),
        .JumpFlagToPc(JumpFlagToPc), .JumpAddrToPc(JumpAddrToPc),
        .StallOut(StallOut), .FlushOut(FlushOut), .Timeout(Timeout),
        .PerfStallCnt(PerfStallCnt), .PerfFlushCnt(PerfFlushCnt),
        .PerfLoadUseCnt(PerfLoadUseCnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] perf_exp(input int n);
`ifdef PIPE_CTRL_PERF_EN
        return 32'(n);
`else
        return (n < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    // Reference model: tracks "waiting", flush slots left, wait length, sticky timeout, event counts.
    bit          m_on = 0, m_wait = 0, m_to = 0, lu_hit, fire;
    int          m_fl = 0, m_wd = 0, m_ns = 0, m_nj = 0, m_nl = 0;
    logic [4:0]  es, ef;
    logic        ej;
    logic [63:0] ea;

    always @(negedge Clk) begin
        if (Rst) begin
            m_on = 1; m_wait = 0; m_to = 0;
            m_fl = 0; m_wd = 0; m_ns = 0; m_nj = 0; m_nl = 0;
        end else if (m_on) begin
            check("m_perf_stall", {32'd0, PerfStallCnt},   {32'd0, perf_exp(m_ns)});
            check("m_perf_flush", {32'd0, PerfFlushCnt},   {32'd0, perf_exp(m_nj)});
            check("m_perf_lu",    {32'd0, PerfLoadUseCnt}, {32'd0, perf_exp(m_nl)});
            es = '0; ef = '0; ej = 0; ea = '0; fire = 0;
            lu_hit = ExIsLoad && (ExRdAddr != 0) &&
                     ((IdRs1ReadEnable && IdRs1Addr == ExRdAddr) ||
                      (IdRs2ReadEnable && IdRs2Addr == ExRdAddr));
            if (m_wait) begin
                if (MemReady) m_wait = 0;
                else if (m_wd >= MS) begin fire = 1; m_wait = 0; m_fl = 0; end
                else begin es = 5'b11111; m_wd++; m_ns++; end
            end else if (MemReq && !MemReady) begin
                es = 5'b11111; m_wait = 1; m_wd = 1; m_ns++;
            end else if (JumpFlagFromEx) begin
                ej = 1; ea = JumpAddrFromEx; ef = 5'b00110; m_nj++; m_fl = FC - 1;
            end else if (m_fl > 0) begin
                ef = 5'b00010; m_fl--;
            end else if (lu_hit) begin
                es = 5'b00011; ef = 5'b00100; m_nl++;
            end
            check("m_stall",   {59'd0, StallOut}, {59'd0, es});
            check("m_flush",   {59'd0, FlushOut}, {59'd0, ef});
            check("m_jflag",   {63'd0, JumpFlagToPc}, {63'd0, ej});
            check("m_jaddr",   JumpAddrToPc, ea);
            check("m_timeout", {63'd0, Timeout}, {63'd0, (m_to | fire)});
            m_to = m_to | fire;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        JumpFlagFromEx = 0; JumpAddrFromEx = '0; ExIsLoad = 0; ExRdAddr = '0;
        IdRs1Addr = '0; IdRs1ReadEnable = 0; IdRs2Addr = '0; IdRs2ReadEnable = 0;
        MemReq = 0; MemReady = 0;
    endtask

    initial begin
        clr();
        Rst = 1; tick(); tick(); Rst = 0;
        #1;
        check("rst_stall", {59'd0, StallOut}, 64'd0);
        check("rst_flush", {59'd0, FlushOut}, 64'd0);
        check("rst_jflag", {63'd0, JumpFlagToPc}, 64'd0);
        check("rst_timeout", {63'd0, Timeout}, 64'd0);
        check("rst_perf", {32'd0, PerfStallCnt | PerfFlushCnt | PerfLoadUseCnt}, 64'd0);
        tick();

        // Jump with three flush cycles.
        JumpFlagFromEx = 1; JumpAddrFromEx = 64'h8000_0100; #1;
        check("jmp_flag", {63'd0, JumpFlagToPc}, 64'd1);
        check("jmp_addr", JumpAddrToPc, 64'h8000_0100);
        check("jmp_flush0", {59'd0, FlushOut}, 64'b00110);
        tick(); clr(); #1;
        check("jmp_flush1", {59'd0, FlushOut}, 64'b00010);
        check("jmp_addr_zero", JumpAddrToPc, 64'd0);
        tick(); #1;
        check("jmp_flush2", {59'd0, FlushOut}, 64'b00010);
        tick(); #1;
        check("jmp_flush3", {59'd0, FlushOut}, 64'b00000);
        tick();

        // Load-use on rs2, then rd=x0, then on rs1.
        ExIsLoad = 1; ExRdAddr = 5; IdRs2Addr = 5; IdRs2ReadEnable = 1; #1;
        check("lu_stall", {59'd0, StallOut}, 64'b00011);
        check("lu_flush", {59'd0, FlushOut}, 64'b00100);
        tick(); ExRdAddr = 0; IdRs2Addr = 0; #1;
        check("lu_x0_stall", {59'd0, StallOut}, 64'd0);
        tick(); clr(); ExIsLoad = 1; ExRdAddr = 7; IdRs1Addr = 7; IdRs1ReadEnable = 1; #1;
        check("lu_rs1_stall", {59'd0, StallOut}, 64'b00011);
        tick(); IdRs1ReadEnable = 0; #1;
        check("lu_dis_stall", {59'd0, StallOut}, 64'd0);
        tick(); clr();

        // Four-cycle memory wait.
        MemReq = 1; MemReady = 0;
        for (int i = 0; i < 4; i++) begin
            #1; check("mw_stall", {59'd0, StallOut}, 64'b11111); tick();
        end
        MemReady = 1; #1;
        check("mw_release", {59'd0, StallOut}, 64'd0);
        tick(); clr(); #1;
        check("mw_perf_stall", {32'd0, PerfStallCnt}, {32'd0, perf_exp(4)});
        check("mw_perf_flush", {32'd0, PerfFlushCnt}, {32'd0, perf_exp(1)});
        check("mw_perf_lu", {32'd0, PerfLoadUseCnt}, {32'd0, perf_exp(2)});
        tick();

        // Memory wait inside FLUSH resumes the remaining flush slot; jump ignored while waiting.
        JumpFlagFromEx = 1; JumpAddrFromEx = 64'h40; tick(); clr(); tick();
        MemReq = 1; JumpFlagFromEx = 1; #1;
        check("mwf_stall", {59'd0, StallOut}, 64'b11111);
        check("mwf_noflush", {59'd0, FlushOut}, 64'd0);
        tick(); #1;
        check("mwf_nojump", {63'd0, JumpFlagToPc}, 64'd0);
        tick(); JumpFlagFromEx = 0; MemReady = 1; tick(); clr(); #1;
        check("mwf_resume", {59'd0, FlushOut}, 64'b00010);
        tick(); #1;
        check("mwf_done", {59'd0, FlushOut}, 64'd0);
        tick();

        // Jump and load-use together: jump wins.
        JumpFlagFromEx = 1; JumpAddrFromEx = 64'h1234;
        ExIsLoad = 1; ExRdAddr = 3; IdRs1Addr = 3; IdRs1ReadEnable = 1; #1;
        check("jlu_flag", {63'd0, JumpFlagToPc}, 64'd1);
        check("jlu_flush", {59'd0, FlushOut}, 64'b00110);
        check("jlu_stall", {59'd0, StallOut}, 64'd0);
        tick(); clr(); tick(); tick(); tick();

        // Watchdog.
        MemReq = 1; MemReady = 0;
        for (int i = 0; i < MS; i++) begin
            #1; check("wd_stall", {59'd0, StallOut}, 64'b11111); tick();
        end
        #1;
        check("wd_release", {59'd0, StallOut}, 64'd0);
        check("wd_timeout", {63'd0, Timeout}, 64'd1);
        tick(); clr(); #1;
        check("wd_sticky", {63'd0, Timeout}, 64'd1);
        tick(); tick(); #1;
        check("wd_sticky2", {63'd0, Timeout}, 64'd1);
        Rst = 1; tick(); Rst = 0; #1;
        check("wd_rst", {63'd0, Timeout}, 64'd0);
        check("wd_rst_perf", {32'd0, PerfStallCnt}, 64'd0);
        tick();

        // Reset mid-FLUSH drops pending flush slots.
        JumpFlagFromEx = 1; JumpAddrFromEx = 64'h99; tick(); clr(); #1;
        check("rf_flush", {59'd0, FlushOut}, 64'b00010);
        Rst = 1; tick(); Rst = 0; #1;
        check("rf_after", {59'd0, FlushOut}, 64'd0);
        tick();

        // Mixed traffic checked by the model.
        for (int c = 0; c < 300; c++) begin
            JumpFlagFromEx  = ($urandom_range(0, 5) == 0);
            JumpAddrFromEx  = {$urandom, $urandom};
            ExIsLoad        = $urandom_range(0, 1) == 1;
            ExRdAddr        = 5'($urandom_range(0, 3));
            IdRs1Addr       = 5'($urandom_range(0, 3));
            IdRs1ReadEnable = $urandom_range(0, 1) == 1;
            IdRs2Addr       = 5'($urandom_range(0, 3));
            IdRs2ReadEnable = $urandom_range(0, 1) == 1;
            MemReq          = ($urandom_range(0, 3) == 0);
            MemReady        = ($urandom_range(0, 2) == 0);
            tick();
        end
        clr(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
